// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt router: register offsets, line count
// and the lowest-index priority helper used by the claim register.
package irq_pkg;

  localparam int IRQ_LINES   = 4;
  localparam int IRQ_MAX_SRC = 16;

  typedef enum logic [2:0] {
    IRQ_PEND  = 3'd0,
    IRQ_MASK  = 3'd1,
    IRQ_MODE  = 3'd2,
    IRQ_ROUTE = 3'd3,
    IRQ_ACK   = 3'd4,
    IRQ_CLAIM = 3'd5
  } irq_off_e;

  // Scans from the top so the lowest set index is the last assignment made.
  function automatic logic [3:0] lowest_set(input logic [IRQ_MAX_SRC-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_router_if.sv
// Data-memory bus slice decoded for the interrupt router.
interface irq_router_if;
  logic        sel;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output sel, addr, we, wd, input rd);
  modport slave  (input sel, addr, we, wd, output rd);
endinterface

// File: rtl/irq_sync.sv
// One-bit two-flop synchronizer with a delayed copy for rising-edge detection.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic s,
  output logic rise
);

  logic meta;
  logic p;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
      p    <= 1'b0;
    end else begin
      meta <= a;
      s    <= meta;
      p    <= s;
    end
  end

  assign rise = s & ~p;

endmodule

// File: rtl/irq_router.sv
// Memory-mapped interrupt controller: synchronizes requests, latches edges,
// masks and routes them onto the core's four INT lines, with claim/ack regs.
module irq_router
  import irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     irq_in,
  irq_router_if.slave          bus,
  output logic [IRQ_LINES-1:0] INT
);

  logic [N_SRC-1:0]   s;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   mode;
  logic [N_SRC-1:0]   epend;
  logic [2*N_SRC-1:0] route;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .a    (irq_in[i]),
      .s    (s[i]),
      .rise (rise[i])
    );
  end

  logic             wr;
  logic [N_SRC-1:0] wd_src;
  logic [N_SRC-1:0] ack;
  logic [N_SRC-1:0] mode_chg;

  assign wr       = bus.sel & bus.we;
  assign wd_src   = bus.wd[N_SRC-1:0];
  assign ack      = (wr && bus.addr == IRQ_ACK)  ? wd_src          : '0;
  assign mode_chg = (wr && bus.addr == IRQ_MODE) ? (wd_src ^ mode) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask  <= '0;
      mode  <= '1;
      route <= '0;
      epend <= '0;
    end else begin
      // Mode change clears and swallows a coincident event; a new event beats ACK.
      epend <= ~mode_chg & ((rise & mode) | (epend & ~ack));
      if (wr && bus.addr == IRQ_MASK)  mask  <= wd_src;
      if (wr && bus.addr == IRQ_MODE)  mode  <= wd_src;
      if (wr && bus.addr == IRQ_ROUTE) route <= bus.wd[2*N_SRC-1:0];
    end
  end

  logic [N_SRC-1:0]       pend;
  logic [N_SRC-1:0]       active;
  logic [IRQ_MAX_SRC-1:0] active_w;
  logic [31:0]            claim;
  logic [IRQ_LINES-1:0]   int_lines;

  assign pend     = (mode & epend) | (~mode & s);
  assign active   = pend & mask;
  assign active_w = IRQ_MAX_SRC'(active);
  assign claim    = {|active, 27'd0, lowest_set(active_w)};

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise unassigned paths would infer latches.
  always_comb begin
    int_lines = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (active[i]) int_lines[route[2*i +: 2]] = 1'b1;
    end
  end

  assign INT = int_lines;

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      IRQ_PEND:  rd_mux = 32'(pend);
      IRQ_MASK:  rd_mux = 32'(mask);
      IRQ_MODE:  rd_mux = 32'(mode);
      IRQ_ROUTE: rd_mux = 32'(route);
      IRQ_CLAIM: rd_mux = claim;
      default:   rd_mux = '0;
    endcase
  end

  assign bus.rd = bus.sel ? rd_mux : '0;

  logic unused_wd;
  assign unused_wd = ^bus.wd;

endmodule

// File: tb/tb_irq_router.sv
// Directed bench for irq_router: a sample-history model predicts INT and read
// data every cycle, and hand-computed literals pin the key scenarios.
module tb_irq_router;
  import irq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_in;
  logic [3:0]   int_lines;

  irq_router_if bus ();

  irq_router #(.N_SRC(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .bus    (bus),
    .INT    (int_lines)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Model: irq_in history sampled at each edge; s is the sample from two edges back.
  bit [N-1:0] smp0, smp1, smp2;
  bit [N-1:0] m_mask, m_mode, m_epend;
  int         m_route [N];

  always @(posedge clk) begin : model
    bit [N-1:0] rise_v, ack_v, chg_v;
    bit         wr_v;
    if (!rst) begin
      smp0 = '0; smp1 = '0; smp2 = '0;
      m_mask = '0; m_mode = '1; m_epend = '0;
      for (int i = 0; i < N; i++) m_route[i] = 0;
    end else begin
      wr_v   = bus.sel && bus.we;
      rise_v = smp1 & ~smp2;
      ack_v  = (wr_v && bus.addr == IRQ_ACK)  ? bus.wd[N-1:0] : '0;
      chg_v  = (wr_v && bus.addr == IRQ_MODE) ? (bus.wd[N-1:0] ^ m_mode) : '0;
      for (int i = 0; i < N; i++) begin
        if (chg_v[i])                      m_epend[i] = 1'b0;
        else if (m_mode[i] && rise_v[i])   m_epend[i] = 1'b1;
        else if (ack_v[i])                 m_epend[i] = 1'b0;
      end
      if (wr_v && bus.addr == IRQ_MASK) m_mask = bus.wd[N-1:0];
      if (wr_v && bus.addr == IRQ_MODE) m_mode = bus.wd[N-1:0];
      if (wr_v && bus.addr == IRQ_ROUTE)
        for (int i = 0; i < N; i++) m_route[i] = int'(bus.wd[2*i +: 2]);
      smp2 = smp1; smp1 = smp0; smp0 = irq_in;
    end
  end

  function automatic bit [N-1:0] m_active();
    bit [N-1:0] pnd;
    for (int i = 0; i < N; i++) pnd[i] = m_mode[i] ? m_epend[i] : smp1[i];
    return pnd & m_mask;
  endfunction

  function automatic logic [31:0] exp_int();
    logic [31:0] e = '0;
    bit [N-1:0]  act = m_active();
    for (int i = 0; i < N; i++) if (act[i]) e[m_route[i]] = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] r = '0;
    bit [N-1:0]  act = m_active();
    if (!bus.sel) return '0;
    case (bus.addr)
      3'd0: for (int i = 0; i < N; i++) r[i] = m_mode[i] ? m_epend[i] : smp1[i];
      3'd1: r = 32'(m_mask);
      3'd2: r = 32'(m_mode);
      3'd3: for (int i = 0; i < N; i++) r = r | (32'(m_route[i]) << (2 * i));
      3'd5: for (int i = N - 1; i >= 0; i--) if (act[i]) r = 32'h8000_0000 | 32'(i);
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_int", 32'(int_lines), exp_int());
      check("model_rd", bus.rd, exp_rd());
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wd = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rdc(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    check(name, bus.rd, exp);
  endtask

  task automatic intc(input string name, input logic [3:0] exp);
    check(name, 32'(int_lines), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
    irq_in = 8'hFF;
    rst    = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b1;
    intc("rst_int", 4'h0);
    rdc("rst_mask",  IRQ_MASK,  32'h0);
    rdc("rst_mode",  IRQ_MODE,  32'hFF);
    rdc("rst_claim", IRQ_CLAIM, 32'h0);
    rdc("rst_pend",  IRQ_PEND,  32'h0);
    irq_in = '0;
    step(); step(); step();

    // Edge-mode routing and claim
    wr(IRQ_MASK, 32'h08);
    wr(IRQ_ROUTE, 32'h80);
    irq_in = 8'h08; step(); irq_in = '0;
    intc("edge_k", 4'h0);
    step(); intc("edge_k1", 4'h0);
    step(); intc("edge_k2", 4'b0100);
    rdc("edge_pend",  IRQ_PEND,  32'h08);
    rdc("edge_claim", IRQ_CLAIM, 32'h8000_0003);
    wr(IRQ_ACK, 32'h08);
    intc("edge_ack_int", 4'h0);
    rdc("edge_ack_pend", IRQ_PEND, 32'h0);

    // Event and ACK in the same cycle
    wr(IRQ_MASK, 32'h01);
    irq_in = 8'h01; step(); step(); step();
    intc("coll_pre_int", 4'h1);
    irq_in = '0; step(); step(); step();
    wr(IRQ_ACK, 32'h01);
    intc("coll_clr_int", 4'h0);
    irq_in = 8'h01; step(); step();
    wr(IRQ_ACK, 32'h01);
    rdc("coll_pend", IRQ_PEND, 32'h01);
    intc("coll_int", 4'h1);
    wr(IRQ_ACK, 32'h01);
    rdc("coll_held_pend", IRQ_PEND, 32'h0);
    irq_in = '0; step(); step(); step();

    // Level mode
    wr(IRQ_MODE, 32'hFE);
    wr(IRQ_MASK, 32'h01);
    irq_in = 8'h01;
    step(); intc("lvl_one_edge", 4'h0);
    step(); intc("lvl_on", 4'h1);
    wr(IRQ_ACK, 32'h01);
    intc("lvl_ack", 4'h1);
    irq_in = '0;
    step(); intc("lvl_off1", 4'h1);
    step(); intc("lvl_off2", 4'h0);
    wr(IRQ_MODE, 32'hFF);

    // Priority, masking, routing and register boundaries
    irq_in = 8'h24; step(); step(); step(); irq_in = '0;
    wr(IRQ_MASK, 32'h24);
    rdc("prio_claim_2", IRQ_CLAIM, 32'h8000_0002);
    intc("prio_int", 4'h1);
    wr(IRQ_MASK, 32'h20);
    rdc("prio_claim_5", IRQ_CLAIM, 32'h8000_0005);
    wr(IRQ_ROUTE, 32'h0C80);
    intc("route_line3", 4'b1000);
    rdc("route_rd", IRQ_ROUTE, 32'h0C80);
    wr(IRQ_MASK, 32'h00);
    rdc("mask0_claim", IRQ_CLAIM, 32'h0);
    intc("mask0_int", 4'h0);
    rdc("mask0_pend", IRQ_PEND, 32'h24);
    wr(IRQ_MASK, 32'hFFFF_FF24);
    rdc("mask_upper", IRQ_MASK, 32'h24);
    wr(IRQ_ROUTE, 32'hFFFF_FFFF);
    rdc("route_upper", IRQ_ROUTE, 32'h0000_FFFF);
    wr(IRQ_ROUTE, 32'h80);
    wr(3'd6, 32'hFFFF_FFFF);
    rdc("off6", 3'd6, 32'h0);
    rdc("off7", 3'd7, 32'h0);
    rdc("ack_rd", IRQ_ACK, 32'h0);
    bus.sel = 1'b0; #1;
    check("unsel_rd", bus.rd, 32'h0);
    wr(IRQ_MODE, 32'hDF);
    wr(IRQ_MODE, 32'hFF);
    rdc("mode_chg_pend", IRQ_PEND, 32'h04);
    wr(IRQ_ACK, 32'hFF);
    wr(IRQ_MASK, 32'h00);

    // Reset in the middle of operation
    irq_in = 8'h42; step(); step(); step();
    wr(IRQ_MASK, 32'h42);
    intc("mr_int", 4'h1);
    rdc("mr_pend", IRQ_PEND, 32'h42);
    rst = 1'b0; step(); rst = 1'b1;
    intc("mr_int0", 4'h0);
    rdc("mr_pend0", IRQ_PEND, 32'h0);
    rdc("mr_mask0", IRQ_MASK, 32'h0);
    step();
    rdc("mr_pend1", IRQ_PEND, 32'h0);
    step(); step(); step(); step();
    intc("mr_stale_int", 4'h0);
    irq_in = '0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
